// File: rtl/bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : bus_pkg                                                           |
// | Shared types and constants for the 6502 bus responder: FSM states, region   |
// | select and vector-ROM addresses, plus the region decode helper.            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package bus_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXT_WAIT = 2'd1,
    EXT_DONE = 2'd2
  } state_t;

  // Address region selected by the combinational decode
  typedef enum logic [1:0] {
    REG_RAM = 2'd0,
    REG_VEC = 2'd1,
    REG_EXT = 2'd2
  } region_t;

  // Vector ROM base addresses (lo byte at even address, hi byte at +1)
  localparam logic [15:0] VEC_NMI_ADDR = 16'hFFFA;
  localparam logic [15:0] VEC_RST_ADDR = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_ADDR = 16'hFFFE;

  // RAM sits at the bottom of the map, vectors at the top, everything else
  // goes to the external port.
  function automatic region_t decode_region(input logic [15:0] a,
                                            input int unsigned ram_aw);
    region_t r;
    if ({16'h0000, a} < (32'd1 << ram_aw)) begin
      r = REG_RAM;
    end else if (a >= VEC_NMI_ADDR) begin
      r = REG_VEC;
    end else begin
      r = REG_EXT;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bus_ram                                                           |
// | Single-port synchronous RAM, 8-bit wide, 2**AW deep. The read register     |
// | only updates on read cycles so it holds its last read value across writes. |
// | Reads and writes never coincide, so no read-during-write behaviour needed. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module bus_ram #(
  parameter int AW = 11
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [2**AW];
  logic [7:0] rdata_q;

  // Storage array and registered read port; contents are never reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bus_responder                                                     |
// | Memory-side responder for the 6502 core bus. Decodes each core cycle into  |
// | internal RAM, a hardwired vector ROM (0xFFFA-0xFFFF) or an external slow   |
// | port with req/ack handshake, and stalls the core via READY while external  |
// | accesses are outstanding.                                                  |
// | Optional feature macro: BUS_TIMEOUT_EN (external wait timeout + bus_err).  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module bus_responder
  import bus_pkg::*;
#(
  parameter int          RAM_AW         = 11,
  parameter logic [15:0] NMI_VEC        = 16'h0000,
  parameter logic [15:0] RST_VEC        = 16'h0000,
  parameter logic [15:0] IRQ_VEC        = 16'h0000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        RW,
  output logic [7:0]  rdata,
  output logic        READY,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  output logic        bus_err
);

  state_t      state_q, state_d;
  region_t     region;
  logic [7:0]  rdata_q, rdata_d;
  logic        rsel_ram_q, rsel_ram_d;   // 1: rdata comes from the RAM read register
  logic        ext_req_q, ext_req_d;
  logic        ext_we_q, ext_we_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic [7:0]  ext_wdata_q, ext_wdata_d;
  logic        bus_err_q, bus_err_d;
  logic        ready_c;
  logic        ram_we, ram_re;
  logic [7:0]  ram_rdata;
  logic        timeout;

  // Vector byte lookup: addr[2:1] picks the vector, addr[0] picks hi/lo
  function automatic logic [7:0] vec_byte(input logic [2:0] a);
    logic [15:0] v;
    unique case (a[2:1])
      2'b01:   v = NMI_VEC;
      2'b10:   v = RST_VEC;
      2'b11:   v = IRQ_VEC;
      default: v = 16'h0000;
    endcase
    return a[0] ? v[15:8] : v[7:0];
  endfunction

  assign region = decode_region(addr, RAM_AW);

  bus_ram #(
    .AW (RAM_AW)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (addr[RAM_AW-1:0]),
    .wdata_i (wdata),
    .rdata_o (ram_rdata)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  // Wait counter runs only while EXT_WAIT persists into the next cycle
  always_comb begin
    cnt_d = '0;
    if (state_q == EXT_WAIT && state_d == EXT_WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Wait counter register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Ack in the same cycle takes priority, hence the ~ext_ack term
  assign timeout = (state_q == EXT_WAIT) && (cnt_q == c_cnt_last) && !ext_ack;
`else
  localparam int c_timeout_unused = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Next-state, READY and datapath load decisions
  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b1;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    rdata_d     = rdata_q;
    rsel_ram_d  = rsel_ram_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    bus_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (region)
          REG_RAM: begin
            ram_we = ~RW;
            ram_re = RW;
            if (RW) begin
              rsel_ram_d = 1'b1;
            end
          end
          REG_VEC: begin
            if (RW) begin
              rdata_d    = vec_byte(addr[2:0]);
              rsel_ram_d = 1'b0;
            end
          end
          REG_EXT: begin
            ready_c     = 1'b0;
            ext_req_d   = 1'b1;
            ext_we_d    = ~RW;
            ext_addr_d  = addr;
            ext_wdata_d = wdata;
            state_d     = EXT_WAIT;
          end
          default: ;
        endcase
      end
      EXT_WAIT: begin
        ready_c = 1'b0;
        if (ext_ack) begin
          ext_req_d = 1'b0;
          if (!ext_we_q) begin
            rdata_d    = ext_rdata;
            rsel_ram_d = 1'b0;
          end
          state_d = EXT_DONE;
        end else if (timeout) begin
          ext_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!ext_we_q) begin
            rdata_d    = 8'hFF;
            rsel_ram_d = 1'b0;
          end
          state_d = EXT_DONE;
        end
      end
      EXT_DONE: begin
        // The core still shows the same address here; never re-request
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      rdata_q     <= 8'h00;
      rsel_ram_q  <= 1'b0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= 16'h0000;
      ext_wdata_q <= 8'h00;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      rsel_ram_q  <= rsel_ram_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // READY is forced high while reset is held so the core is never stalled by
  // an external-region address presented during reset.
  assign READY     = ready_c | i_rst;
  assign rdata     = rsel_ram_q ? ram_rdata : rdata_q;
  assign ext_req   = ext_req_q;
  assign ext_we    = ext_we_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign bus_err   = bus_err_q;

endmodule
`default_nettype wire
